inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 118 +++++++++++
 tb/tb_inst_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Front-end stage ahead of the main-control decoder. Holds the PC, fetches a
//   32-bit instruction over a req/ack handshake, presents it (with its 11-bit
//   opcode field) until downstream retires it, then steps or branches the PC.
//
// Ports
//   CLK, resetl          clock (rising edge), synchronous active-low reset
//   startPC              PC loaded while in reset
//   imem_req/addr        fetch request and address (address == pc)
//   imem_ack/rdata       memory response; data valid when ack is high
//   inst_valid/inst      latched instruction is being presented
//   opcode/pc            inst[31:21] and the instruction's address
//   inst_ready           downstream retires the presented instruction
//   branch/uncond_branch/zero/br_offset  resolved branch info, used at retire
//   inst_count           retired instruction count (wraps)
//   fetch_err            sticky error: fetch timeout or misaligned next PC
module inst_fetch_unit #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              resetl,
    input  logic [ADDR_W-1:0] startPC,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [10:0]       opcode,
    output logic [ADDR_W-1:0] pc,
    input  logic              inst_ready,
    input  logic              branch,
    input  logic              uncond_branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] br_offset,
    output logic [CNT_W-1:0]  inst_count,
    output logic              fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    // Counter only needs to reach TIMEOUT-1.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic [CNT_W-1:0]  r_cnt;
    logic [TO_W-1:0]   r_tcnt;

    logic              w_ctl_known;
    logic              w_taken;
    logic [ADDR_W-1:0] w_off4;
    logic [ADDR_W-1:0] w_next;
    logic              w_timeout;

    // An unknown branch control must never redirect the PC; treat it as not taken.
    assign w_ctl_known = ((branch === 1'b0) || (branch === 1'b1)) &&
                         ((uncond_branch === 1'b0) || (uncond_branch === 1'b1));
    assign w_taken     = w_ctl_known &&
                         ((uncond_branch === 1'b1) || ((branch === 1'b1) && (zero === 1'b1)));
    assign w_off4      = br_offset << 2;
    assign w_next      = w_taken ? (r_pc + w_off4) : (r_pc + ADDR_W'(4));
    assign w_timeout   = (TIMEOUT != 0) && (r_tcnt == TO_LAST);

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            r_state <= S_IDLE;
            r_pc    <= startPC;
            r_inst  <= '0;
            r_cnt   <= '0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        r_inst  <= imem_rdata;
                        r_tcnt  <= '0;
                        r_state <= S_ISSUE;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                        if (w_timeout) r_state <= S_ERR;
                    end
                end
                S_ISSUE: begin
                    if (inst_ready) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        // Misaligned target: trap with pc still pointing at the culprit.
                        if (w_next[1:0] != 2'b00) begin
                            r_state <= S_ERR;
                        end else begin
                            r_pc    <= w_next;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_ERR;  // ERR is terminal until reset
            endcase
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign inst_valid = (r_state == S_ISSUE);
    assign inst       = r_inst;
    assign opcode     = r_inst[31:21];
    assign pc         = r_pc;
    assign inst_count = r_cnt;
    assign fetch_err  = (r_state == S_ERR);

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
    localparam int AW = 64;
    localparam int TO = 4;
    localparam int CW = 32;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_ISSUE = 2;
    localparam int P_ERR   = 3;

    logic          CLK = 1'b0;
    logic          resetl;
    logic [AW-1:0] startPC;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [10:0]   opcode;
    logic [AW-1:0] pc;
    logic          inst_ready;
    logic          branch;
    logic          uncond_branch;
    logic          zero;
    logic [AW-1:0] br_offset;
    logic [CW-1:0] inst_count;
    logic          fetch_err;

    inst_fetch_unit #(.ADDR_W(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK(CLK), .resetl(resetl), .startPC(startPC),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .opcode(opcode), .pc(pc),
        .inst_ready(inst_ready), .branch(branch), .uncond_branch(uncond_branch),
        .zero(zero), .br_offset(br_offset),
        .inst_count(inst_count), .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: what the unit is doing, where it is, what it holds.
    int            m_phase = P_IDLE;
    logic [AW-1:0] m_pc    = '0;
    logic [31:0]   m_inst  = '0;
    logic [CW-1:0] m_cnt   = '0;
    int            m_waited = 0;   // FETCH cycles spent without an ack

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [AW-1:0] nxt;
        if (!resetl) begin
            m_phase = P_IDLE; m_pc = startPC; m_inst = '0; m_cnt = '0; m_waited = 0;
            return;
        end
        case (m_phase)
            P_IDLE: m_phase = P_FETCH;
            P_FETCH: begin
                if (imem_ack) begin
                    m_inst = imem_rdata; m_waited = 0; m_phase = P_ISSUE;
                end else begin
                    m_waited++;
                    if (m_waited >= TO) m_phase = P_ERR;  // TO cycles with no ack
                end
            end
            P_ISSUE: begin
                if (inst_ready) begin
                    if (uncond_branch || (branch && zero)) nxt = m_pc + br_offset * 4;
                    else                                   nxt = m_pc + 4;
                    m_cnt = m_cnt + 1;
                    if (nxt % 4 != 0) m_phase = P_ERR;
                    else begin m_pc = nxt; m_phase = P_FETCH; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        chk("imem_req",   64'(imem_req),   64'(m_phase == P_FETCH));
        chk("inst_valid", 64'(inst_valid), 64'(m_phase == P_ISSUE));
        chk("fetch_err",  64'(fetch_err),  64'(m_phase == P_ERR));
        chk("imem_addr",  imem_addr,       m_pc);
        chk("pc",         pc,              m_pc);
        chk("inst",       64'(inst),       64'(m_inst));
        chk("opcode",     64'(opcode),     64'(m_inst >> 21));
        chk("inst_count", 64'(inst_count), 64'(m_cnt));
    endtask

    // One clock: inputs already driven; model follows the edge; compare on negedge.
    task automatic cyc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        compare_all();
    endtask

    task automatic clr_ctl();
        inst_ready = 0; branch = 0; uncond_branch = 0; zero = 0; br_offset = '0;
    endtask

    // Leaves the unit in its first FETCH cycle at address p.
    task automatic reset_to(input logic [AW-1:0] p);
        resetl = 0; startPC = p; imem_ack = 0; clr_ctl();
        cyc(); cyc();
        resetl = 1;
        cyc();
    endtask

    task automatic fetch_ok(input logic [31:0] w);
        imem_ack = 1; imem_rdata = w;
        cyc();
        imem_ack = 0;
    endtask

    task automatic retire(input logic u, input logic b, input logic z, input logic [AW-1:0] off);
        uncond_branch = u; branch = b; zero = z; br_offset = off; inst_ready = 1;
        cyc();
        clr_ctl();
    endtask

    initial begin
        logic [31:0] w;
        resetl = 0; startPC = '0; imem_ack = 0; imem_rdata = '0; clr_ctl();

        // Reset state and basic fetch/retire
        startPC = 64'h100;
        cyc(); cyc();
        chk("rst imem_req",   64'(imem_req), 64'd0);
        chk("rst inst_valid", 64'(inst_valid), 64'd0);
        chk("rst opcode",     64'(opcode), 64'd0);
        chk("rst count",      64'(inst_count), 64'd0);
        chk("rst fetch_err",  64'(fetch_err), 64'd0);
        resetl = 1; imem_ack = 1; imem_rdata = 32'hF84003E9; inst_ready = 1;
        cyc();
        chk("first req",  64'(imem_req), 64'd1);
        chk("first addr", imem_addr, 64'h100);
        cyc();
        chk("first valid",  64'(inst_valid), 64'd1);
        chk("first opcode", 64'(opcode), 64'h7C2);
        cyc();
        chk("next addr",  imem_addr, 64'h104);
        chk("count one",  64'(inst_count), 64'd1);
        imem_ack = 0; clr_ctl();

        // Branch resolution
        reset_to(64'h200); fetch_ok(32'h1234_5678);
        retire(1, 0, 0, -64'sd2);
        chk("uncond target", imem_addr, 64'h1F8);
        reset_to(64'h200); fetch_ok(32'h1234_5678);
        retire(0, 1, 0, 64'd3);
        chk("br not taken", imem_addr, 64'h204);
        reset_to(64'h200); fetch_ok(32'h1234_5678);
        retire(0, 1, 1, 64'd3);
        chk("br taken", imem_addr, 64'h20C);

        // Fetch timeout
        reset_to(64'h300);
        cyc(); cyc(); cyc();
        chk("to not yet err", 64'(fetch_err), 64'd0);
        chk("to still req",   64'(imem_req), 64'd1);
        cyc();
        chk("to err",    64'(fetch_err), 64'd1);
        chk("to no req", 64'(imem_req), 64'd0);
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) cyc();
        chk("late ack ignored", 64'(inst), 64'd0);
        imem_ack = 0;
        reset_to(64'h300);
        chk("reset clears err", 64'(fetch_err), 64'd0);

        // Long stall in ISSUE
        reset_to(64'h400); fetch_ok(32'hABCD_0123);
        for (int i = 0; i < 10; i++) cyc();
        chk("stall inst",  64'(inst), 64'hABCD_0123);
        chk("stall pc",    pc, 64'h400);
        chk("stall count", 64'(inst_count), 64'd0);
        retire(0, 0, 0, '0);
        cyc(); cyc();
        chk("one retire", 64'(inst_count), 64'd1);

        // Address wrap and misalignment
        reset_to(64'hFFFF_FFFF_FFFF_FFFC); fetch_ok(32'h1);
        retire(0, 0, 0, '0);
        chk("wrap pc",  pc, 64'h0);
        chk("wrap err", 64'(fetch_err), 64'd0);
        reset_to(64'h102); fetch_ok(32'h2);
        retire(1, 0, 0, 64'h4000_0000_0000_0001);
        chk("misalign err", 64'(fetch_err), 64'd1);
        chk("misalign pc",  pc, 64'h102);

        // Reset mid-FETCH with a coincident ack
        reset_to(64'h500); fetch_ok(32'h5); retire(0, 0, 0, '0);
        resetl = 0; imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        cyc();
        chk("rstf inst",  64'(inst), 64'd0);
        chk("rstf req",   64'(imem_req), 64'd0);
        chk("rstf pc",    pc, 64'h500);
        chk("rstf count", 64'(inst_count), 64'd0);
        imem_ack = 0;

        // Randomized traffic against the model
        reset_to(64'h1000);
        for (int i = 0; i < 4000; i++) begin
            int k;
            resetl     = ($urandom_range(0, 99) >= 2);
            startPC    = {$urandom, $urandom};
            if ($urandom_range(0, 15) != 0) startPC[1:0] = 2'b00;
            imem_ack   = $urandom_range(0, 1);
            w          = $urandom;
            imem_rdata = w;
            inst_ready = ($urandom_range(0, 9) < 4);
            branch     = $urandom_range(0, 1);
            uncond_branch = ($urandom_range(0, 3) == 0);
            zero       = $urandom_range(0, 1);
            k          = int'($urandom_range(0, 64)) - 32;
            br_offset  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : AW'(longint'(k));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
